// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, state type and small-sigma helpers used by the hashing datapath stages.
package sha256_pkg;

   localparam int DATA_WID  = 32;
   localparam int ROUND_NUM = 64;

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [DATA_WID-1:0] K_TABLE [ROUND_NUM] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [DATA_WID-1:0] ssig0(input logic [DATA_WID-1:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [DATA_WID-1:0] ssig1(input logic [DATA_WID-1:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational SHA-256 round-constant ROM: 6-bit round index to K[t].
module sha256_k_rom
   import sha256_pkg::*;
(
   input  logic [5:0]          idx_i,
   output logic [DATA_WID-1:0] k_o
);

   assign k_o = K_TABLE[idx_i];

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: 16-word sliding window expanding one block into W[0..63] with K[t].
// Optional SHA256_MSG_SCHED_ROUND_IDX_EN adds ov_round_idx and o_last_w outputs.
module sha256_msg_schedule #(
   parameter int WORD_NUM  = 16,
   parameter int DATA_WID  = 32,
   parameter int ROUND_NUM = 64
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [WORD_NUM*DATA_WID-1:0] iv_m_data,
   input  logic                         i_m_data_vld,
   output logic                         o_m_data_rdy,
   output logic [DATA_WID-1:0]          ov_w_data,
   output logic [DATA_WID-1:0]          ov_k_data,
   output logic                         o_w_data_vld,
   input  logic                         i_w_data_rdy,
   output logic                         o_blk_done
`ifdef SHA256_MSG_SCHED_ROUND_IDX_EN
   ,
   output logic [5:0]                   ov_round_idx,
   output logic                         o_last_w
`endif
);
   import sha256_pkg::*;

   localparam logic [5:0] LAST_T = 6'(ROUND_NUM - 1);

   state_t              state_q, state_d;
   logic [5:0]          t_q, t_d;
   logic [DATA_WID-1:0] win_q [WORD_NUM];
   logic [DATA_WID-1:0] win_d [WORD_NUM];
   logic                rdy_q, rdy_d;
   logic                done_q, done_d;
   logic [DATA_WID-1:0] newWord;

   assign newWord = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      win_d   = win_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_m_data_vld && rdy_q) begin
               for (int i = 0; i < WORD_NUM; i++) begin
                  win_d[i] = iv_m_data[DATA_WID*i +: DATA_WID];
               end
               t_d     = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (i_w_data_rdy) begin
               for (int j = 0; j < WORD_NUM-1; j++) begin
                  win_d[j] = win_q[j+1];
               end
               win_d[WORD_NUM-1] = newWord;
               if (t_q == LAST_T) begin
                  state_d = IDLE;
                  t_d     = '0;
                  done_d  = 1'b1;
               end else begin
                  t_d = t_q + 6'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Ready is registered, so it is 0 through reset and the accept cycle and rises once back in IDLE.
      rdy_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         t_q     <= '0;
         rdy_q   <= 1'b0;
         done_q  <= 1'b0;
         for (int i = 0; i < WORD_NUM; i++) begin
            win_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         rdy_q   <= rdy_d;
         done_q  <= done_d;
         win_q   <= win_d;
      end
   end

   sha256_k_rom u_k_rom (
      .idx_i (t_q),
      .k_o   (ov_k_data)
   );

   assign o_m_data_rdy = rdy_q;
   assign o_w_data_vld = (state_q == RUN);
   assign ov_w_data    = win_q[0];
   assign o_blk_done   = done_q;

`ifdef SHA256_MSG_SCHED_ROUND_IDX_EN
   logic last_q, last_d;

   assign last_d = (state_d == RUN) && (t_d == LAST_T);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_q <= 1'b0;
      end else begin
         last_q <= last_d;
      end
   end

   assign ov_round_idx = t_q;
   assign o_last_w     = last_q;
`endif

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Bench for sha256_msg_schedule: vector table, flow-control sequences and random blocks scored
// against a W[t] recurrence model with K derived from cube roots of primes.
module tb_sha256_msg_schedule;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [511:0]  mData;
   logic          mVld;
   logic          mRdy;
   logic [31:0]   wData;
   logic [31:0]   kData;
   logic          wVld;
   logic          wRdy;
   logic          blkDone;
`ifdef SHA256_MSG_SCHED_ROUND_IDX_EN
   logic [5:0]    roundIdx;
   logic          lastW;
`endif

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] w;
      int          idx;
   } expEntry_t;

   typedef struct {
      logic [511:0] blk;
      int           idx;
      bit           chkW;
      logic [31:0]  expW;
      logic [31:0]  expK;
   } vecRec_t;

   logic [31:0] benchK [64];
   logic [31:0] modelW [64];
   expEntry_t   expQ [$];
   logic [31:0] xferW [$];
   logic [31:0] xferK [$];
   int          xferCyc [$];
   int          xferCount = 0;
   int          doneCount = 0;
   int          lastDoneCyc = -1;
   int          acceptCyc = -1;
   bit          doneExp = 1'b0;
   bit          heldPrev = 1'b0;
   logic [31:0] heldW;
   logic [31:0] heldK;

   sha256_msg_schedule dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .iv_m_data    (mData),
      .i_m_data_vld (mVld),
      .o_m_data_rdy (mRdy),
      .ov_w_data    (wData),
      .ov_k_data    (kData),
      .o_w_data_vld (wVld),
      .i_w_data_rdy (wRdy),
      .o_blk_done   (blkDone)
`ifdef SHA256_MSG_SCHED_ROUND_IDX_EN
      ,
      .ov_round_idx (roundIdx),
      .o_last_w     (lastW)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] sigma0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sigma1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // K[t] is the first 32 fraction bits of the cube root of the t-th prime.
   task automatic computeK();
      int  p;
      int  n;
      bit  isPrime;
      real r;
      p = 2;
      n = 0;
      while (n < 64) begin
         isPrime = 1'b1;
         for (int d = 2; d * d <= p; d++) begin
            if (p % d == 0) isPrime = 1'b0;
         end
         if (isPrime) begin
            r = $pow(real'(p), 1.0 / 3.0);
            benchK[n] = 32'(longint'($floor((r - $floor(r)) * 4294967296.0)));
            n++;
         end
         p++;
      end
   endtask

   task automatic pushBlock(input logic [511:0] blk);
      logic [31:0] w [64];
      for (int t = 0; t < 64; t++) begin
         if (t < 16) w[t] = blk[32*t +: 32];
         else        w[t] = sigma1(w[t-2]) + w[t-7] + sigma0(w[t-15]) + w[t-16];
      end
      for (int t = 0; t < 64; t++) begin
         modelW[t] = w[t];
         expQ.push_back('{w: w[t], idx: t});
      end
   endtask

   function automatic logic [511:0] randBlock();
      logic [511:0] b;
      for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
      return b;
   endfunction

   always @(negedge clk) begin
      expEntry_t e;
      bit        doneNow;
      doneNow = doneExp;
      doneExp = 1'b0;
      if (rst_n !== 1'b1) begin
         expQ.delete();
         heldPrev = 1'b0;
      end else begin
         if (blkDone === 1'b1 || doneNow) begin
            checkOutput("blk_done", blkDone, doneNow);
            if (blkDone === 1'b1) begin
               doneCount++;
               lastDoneCyc = cyc;
            end
         end
         if (heldPrev) begin
            checkOutput("hold_vld", wVld, 1'b1);
            checkOutput("hold_w", wData, heldW);
            checkOutput("hold_k", kData, heldK);
         end
         heldPrev = 1'b0;
`ifdef SHA256_MSG_SCHED_ROUND_IDX_EN
         if (wVld === 1'b1 && expQ.size() > 0) begin
            checkOutput("round_idx", roundIdx, expQ[0].idx);
            checkOutput("last_w", lastW, expQ[0].idx == 63);
         end else if (wVld !== 1'b1) begin
            checkOutput("last_w_idle", lastW, 1'b0);
         end
`endif
         if (wVld === 1'b1 && wRdy === 1'b1) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_w", 1, 0);
            end else begin
               e = expQ.pop_front();
               checkOutput("w_data", wData, e.w);
               checkOutput("k_data", kData, benchK[e.idx]);
               if (e.idx == 63) doneExp = 1'b1;
            end
            xferW.push_back(wData);
            xferK.push_back(kData);
            xferCyc.push_back(cyc);
            xferCount++;
         end else if (wVld === 1'b1) begin
            heldPrev = 1'b1;
            heldW    = wData;
            heldK    = kData;
         end
         if (mVld === 1'b1 && mRdy === 1'b1) begin
            pushBlock(mData);
            acceptCyc = cyc;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [511:0] blk);
      int n;
      mData = blk;
      mVld  = 1'b1;
      n = 0;
      while (mRdy !== 1'b1 && n < 200) begin
         step();
         n++;
      end
      if (mRdy !== 1'b1) checkOutput("accept_timeout", 0, 1);
      step();
      mVld = 1'b0;
   endtask

   task automatic waitXfers(input int target, input int budget, input bit randRdy);
      int n;
      n = 0;
      while (xferCount < target && n < budget) begin
         if (randRdy) wRdy = ($urandom_range(0, 3) != 0);
         step();
         n++;
      end
      wRdy = 1'b1;
      if (xferCount < target) checkOutput("xfer_timeout", xferCount, target);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish (errors=%0d)", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecRec_t      vecs [7];
      logic [511:0] abcBlk;
      logic [511:0] onesBlk;
      logic [511:0] blkA;
      logic [511:0] blkB;
      int           base;
      int           accA;
      int           accB;
      int           doneBefore;
      int           n;

      computeK();
      abcBlk = '0;
      abcBlk[31:0]    = 32'h61626380;
      abcBlk[511:480] = 32'h00000018;
      onesBlk = '1;

      vecs[0] = '{abcBlk,  0, 1'b1, 32'h61626380, 32'h428a2f98};
      vecs[1] = '{abcBlk,  1, 1'b1, 32'h00000000, 32'h71374491};
      vecs[2] = '{abcBlk, 15, 1'b1, 32'h00000018, 32'hc19bf174};
      vecs[3] = '{abcBlk, 16, 1'b1, 32'h61626380, 32'he49b69c1};
      vecs[4] = '{abcBlk, 17, 1'b1, 32'h000f0000, 32'hefbe4786};
      vecs[5] = '{abcBlk, 63, 1'b0, 32'h00000000, 32'hc67178f2};
      vecs[6] = '{onesBlk, 16, 1'b1, 32'h203ffffc, 32'he49b69c1};

      rst_n = 1'b0;
      mVld  = 1'b0;
      mData = '0;
      wRdy  = 1'b1;
      step();
      step();
      checkOutput("reset_vld", wVld, 1'b0);
      checkOutput("reset_done", blkDone, 1'b0);
      checkOutput("reset_w", wData, 32'h0);
      checkOutput("reset_k", kData, 32'h428a2f98);
      checkOutput("reset_rdy", mRdy, 1'b0);
`ifdef SHA256_MSG_SCHED_ROUND_IDX_EN
      checkOutput("reset_round_idx", roundIdx, 6'd0);
      checkOutput("reset_last_w", lastW, 1'b0);
`endif
      rst_n = 1'b1;
      step();
      checkOutput("rdy_after_reset", mRdy, 1'b1);
      checkOutput("vld_after_reset", wVld, 1'b0);

      $display("[TB] vector table");
      base = 0;
      for (int v = 0; v < 7; v++) begin
         if (v == 0 || vecs[v].blk != vecs[v-1].blk) begin
            base = xferCount;
            doneBefore = doneCount;
            applyStimulus(vecs[v].blk);
            waitXfers(base + 64, 300, 1'b0);
            step();
            checkOutput($sformatf("vec%0d_done_count", v), doneCount - doneBefore, 1);
            if (v == 0) begin
               checkOutput("w0_latency", xferCyc[base], acceptCyc + 1);
               checkOutput("w63_cycle", xferCyc[base+63], acceptCyc + 64);
               checkOutput("done_cycle", lastDoneCyc, acceptCyc + 65);
            end
         end
         if (vecs[v].chkW) begin
            checkOutput($sformatf("vec%0d_w%0d", v, vecs[v].idx), xferW[base + vecs[v].idx], vecs[v].expW);
         end
         checkOutput($sformatf("vec%0d_k%0d", v, vecs[v].idx), xferK[base + vecs[v].idx], vecs[v].expK);
      end

      $display("[TB] backpressure at t=20");
      base = xferCount;
      applyStimulus(randBlock());
      n = 0;
      while (xferCount < base + 20 && n < 100) begin
         step();
         n++;
      end
      wRdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checkOutput("bp_vld", wVld, 1'b1);
         checkOutput("bp_w20", wData, modelW[20]);
         checkOutput("bp_k20", kData, benchK[20]);
         step();
      end
      wRdy = 1'b1;
      waitXfers(base + 64, 200, 1'b0);
      step();
      checkOutput("bp_after_w20", xferW[base+20], modelW[20]);
      checkOutput("bp_after_w21", xferW[base+21], modelW[21]);
      checkOutput("bp_count", xferCount - base, 64);

      $display("[TB] back-to-back blocks");
      blkA = randBlock();
      blkB = randBlock();
      base = xferCount;
      doneBefore = doneCount;
      mData = blkA;
      mVld  = 1'b1;
      n = 0;
      while (mRdy !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      step();
      accA  = acceptCyc;
      mData = blkB;
      n = 0;
      while (mRdy !== 1'b1 && n < 200) begin
         step();
         n++;
      end
      step();
      mVld = 1'b0;
      accB = acceptCyc;
      waitXfers(base + 128, 400, 1'b0);
      step();
      checkOutput("b2b_accept_cycle", accB, accA + 65);
      checkOutput("b2b_count", xferCount - base, 128);
      checkOutput("b2b_done_count", doneCount - doneBefore, 2);
      checkOutput("b2b_first_w0", xferW[base], blkA[31:0]);
      checkOutput("b2b_second_w0", xferW[base+64], blkB[31:0]);

      $display("[TB] random blocks with random downstream ready");
      for (int r = 0; r < 3; r++) begin
         base = xferCount;
         applyStimulus(randBlock());
         waitXfers(base + 64, 1000, 1'b1);
         step();
         checkOutput($sformatf("rand%0d_count", r), xferCount - base, 64);
      end

      $display("[TB] reset mid-block at t=30");
      base = xferCount;
      applyStimulus(randBlock());
      n = 0;
      while (xferCount < base + 30 && n < 100) begin
         step();
         n++;
      end
      doneBefore = doneCount;
      rst_n = 1'b0;
      step();
      checkOutput("rst_mid_vld", wVld, 1'b0);
      checkOutput("rst_mid_done", blkDone, 1'b0);
      checkOutput("rst_mid_rdy", mRdy, 1'b0);
      rst_n = 1'b1;
      step();
      checkOutput("rst_release_rdy", mRdy, 1'b1);
      checkOutput("rst_release_vld", wVld, 1'b0);
      for (int i = 0; i < 5; i++) step();
      checkOutput("rst_no_done", doneCount - doneBefore, 0);
      checkOutput("rst_xfer_stop", xferCount - base, 30);
      base = xferCount;
      applyStimulus(abcBlk);
      waitXfers(base + 64, 200, 1'b0);
      step();
      checkOutput("rst_restart_w0", xferW[base], 32'h61626380);
      checkOutput("rst_restart_k0", xferK[base], 32'h428a2f98);
      checkOutput("rst_restart_count", xferCount - base, 64);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sha256_msg_schedule.md
# sha256_msg_schedule

Message-schedule stage of the double-SHA-256 datapath. It accepts one 512-bit padded message block and emits the 64 expanded words W[0..63] one per accepted transfer, each paired with its round constant K[t]. Its output feeds the round-compression stage directly: W drives the round's W input, its valid drives the round's W-valid, and K drives the round's K input. It uses a 16-word sliding window plus a round counter, with ready/valid flow control on both sides.

## Interface
Parameters:
- WORD_NUM, 16, words per message block
- DATA_WID, 32, word width in bits
- ROUND_NUM, 64, expanded words per block

Ports:
- clk  in  1  single clock; all logic is on its rising edge
- rst_n  in  1  reset, synchronous and active-low (clk domain)
- iv_m_data  in  WORD_NUM*DATA_WID  message block; word i is at [DATA_WID*i +: DATA_WID], word 0 = M0
- i_m_data_vld  in  1  message block valid
- o_m_data_rdy  out  1  block accepted on the cycle where vld & rdy
- ov_w_data  out  DATA_WID  current expanded word W[t]
- ov_k_data  out  DATA_WID  round constant K[t], aligned with ov_w_data
- o_w_data_vld  out  1  W/K valid
- i_w_data_rdy  in  1  downstream accepts W/K on the cycle where vld & rdy
- o_blk_done  out  1  one-cycle pulse on the cycle after W[63] is transferred

## Operation
- States: IDLE and RUN. Round counter t is 6 bits; window win[0..15] holds 16 words of DATA_WID bits.
- IDLE:
  - o_m_data_rdy=1, o_w_data_vld=0.
  - On i_m_data_vld: win[i] <= M[i], t <= 0, go to RUN.
- RUN:
  - o_m_data_rdy=0, o_w_data_vld=1, ov_w_data=win[0], ov_k_data=K[t].
- Transfer (vld & i_w_data_rdy):
  - Window shifts: win[j] <= win[j+1] for j=0..14.
  - New word: win[15] <= ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0], which is W[t+16].
  - The sum is modulo 2^DATA_WID; carries are discarded.
  - t <= t+1.
- Sigma functions:
  - ssig0(x) = ror7 ^ ror18 ^ shr3
  - ssig1(x) = ror17 ^ ror19 ^ shr10
- Words computed past W[63] are don't-care and are never presented.
- Transfer at t=63: go to IDLE, t <= 0, o_blk_done=1 on the next cycle.
- No transfer (i_w_data_rdy=0): window, t, ov_w_data and ov_k_data all hold; o_w_data_vld stays 1.
- i_m_data_vld while in RUN: ignored; the block stays pending until IDLE.

## Timing
- Reset values (rst_n low at a clock edge): state IDLE, t=0, win all 0.
  - Outputs during reset: o_w_data_vld=0, o_blk_done=0, ov_w_data=0, ov_k_data=K[0]=0x428a2f98, o_m_data_rdy=0.
  - o_m_data_rdy is driven from a register that is 0 in reset and 1 in IDLE, so it rises on the first cycle after rst_n goes high.
- Latency: block accepted at cycle N → W[0] valid at N+1.
- Throughput: with downstream always ready, W[t] appears at N+1+t and W[63] at N+64.
- o_blk_done is high at N+65; that is also the first cycle o_m_data_rdy=1 again. The next block can therefore be accepted at N+65, and its W[0] appears at N+66.
- Reset mid-RUN: the next cycle is in IDLE with o_w_data_vld=0. No partial block is resumed, and no o_blk_done pulse is produced.
- All outputs are registered except ov_k_data, which is a ROM lookup indexed by the registered t.

## Configuration
- Macro: SHA256_MSG_SCHED_ROUND_IDX_EN.
- Defined: adds two outputs.
  - ov_round_idx (6 bits) = t.
  - o_last_w (1 bit) = RUN & t==63.
  - Both have the same timing as ov_w_data. Reset values: 0.
- Undefined: neither port nor its logic exists. Remaining behaviour is identical.

## Structure
- Shared package sha256_pkg holds:
  - DATA_WID and ROUND_NUM constants
  - the 64-entry K constant array
  - the ssig0/ssig1 functions
  - the state enum {IDLE, RUN}
- One sub-module, sha256_k_rom: combinational, 6-bit index → 32-bit K. It is reused by other stages.

## Test plan
- "abc" block (M0=0x61626380, M1..M14=0, M15=0x00000018), rdy always 1 → W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000. K1=0x71374491; K63=0xc67178f2 with W63. o_blk_done pulses once, 65 cycles after acceptance.
- All-ones block (every M=0xFFFFFFFF) → W16=0x203FFFFC, which checks modulo wrap.
- Backpressure: i_w_data_rdy=0 for 3 cycles while t=20 is presented → W20/K20 held for those 3 cycles, vld stays 1, then W21 follows. Total W count is 64.
- Back-to-back: i_m_data_vld held high with two blocks → the second is accepted on the o_blk_done cycle. 128 W words total; no block is lost or duplicated.
- Reset mid-RUN: rst_n low for 1 cycle at t=30 → vld=0 next cycle, no o_blk_done, rdy=1 after release, and the next block restarts at W0.
- With SHA256_MSG_SCHED_ROUND_IDX_EN defined → ov_round_idx counts 0..63 in step with W, and o_last_w is high only while W63 is presented.
